// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with pixel-rate divider,
// registered sync/blanking, line/frame strobes and blank-gated colour.
//
// Ports:
//   clk_50MHz   in   1   single system clock
//   clear       in   1   synchronous active-high reset, wins over enable
//   enable      in   1   run (1) / hold (0) for divider, counters, syncs
//   red_in      in   8   pixel colour, red
//   green_in    in   8   pixel colour, green
//   blue_in     in   8   pixel colour, blue
//   pix_en      out  1   one-clk tick after each divider wrap
//   h_sync      out  1   horizontal sync, active level H_POL
//   v_sync      out  1   vertical sync, active level V_POL
//   bright      out  1   high while the presented position is visible
//   h_count     out  CB  current pixel within the line
//   v_count     out  CB  current line within the frame
//   line_start  out  1   one-clk pulse after h_count returns to 0
//   frame_start out  1   one-clk pulse after h_count and v_count return to 0
//   sync_n      out  1   DAC sync-on-green control, tied low
//   blank_n     out  1   DAC blanking control, equals bright
//   red_out     out  8   red, forced to 0 outside the visible region
//   green_out   out  8   green, forced to 0 outside the visible region
//   blue_out    out  8   blue, forced to 0 outside the visible region

module vga_timing_gen #(
    parameter int H_RES        = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_RES        = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int COUNTER_BITS = 10,
    parameter int CLK_DIV      = 2,
    parameter int H_POL        = 0,
    parameter int V_POL        = 0
) (
    input  logic                    clk_50MHz,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [7:0]              red_in,
    input  logic [7:0]              green_in,
    input  logic [7:0]              blue_in,
    output logic                    pix_en,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    bright,
    output logic [COUNTER_BITS-1:0] h_count,
    output logic [COUNTER_BITS-1:0] v_count,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    sync_n,
    output logic                    blank_n,
    output logic [7:0]              red_out,
    output logic [7:0]              green_out,
    output logic [7:0]              blue_out
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CB    = COUNTER_BITS;

    generate
        if ((H_TOTAL - 1) >= (2 ** COUNTER_BITS)) begin : g_bad_h
            $error("H_TOTAL-1 does not fit in COUNTER_BITS");
        end
        if ((V_TOTAL - 1) >= (2 ** COUNTER_BITS)) begin : g_bad_v
            $error("V_TOTAL-1 does not fit in COUNTER_BITS");
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("CLK_DIV must be 2 or more");
        end
    endgenerate

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CB-1:0] H_LAST = CB'(H_TOTAL - 1);
    localparam logic [CB-1:0] V_LAST = CB'(V_TOTAL - 1);

    // Region bounds carry one spare bit so a bound equal to 2**CB
    // (zero back porch on a full-width counter) still compares correctly.
    localparam logic [CB:0] H_VIS = (CB + 1)'(H_RES);
    localparam logic [CB:0] H_SS  = (CB + 1)'(H_RES + H_FP);
    localparam logic [CB:0] H_SE  = (CB + 1)'(H_RES + H_FP + H_SYNC);
    localparam logic [CB:0] V_VIS = (CB + 1)'(V_RES);
    localparam logic [CB:0] V_SS  = (CB + 1)'(V_RES + V_FP);
    localparam logic [CB:0] V_SE  = (CB + 1)'(V_RES + V_FP + V_SYNC);

    localparam logic H_ACT = (H_POL != 0);
    localparam logic V_ACT = (V_POL != 0);

    logic [DIV_W-1:0] r_div;
    logic [CB-1:0]    r_h;
    logic [CB-1:0]    r_v;
    logic             r_pix_en;
    logic             r_hs;
    logic             r_vs;
    logic             r_bright;
    logic             r_ls;
    logic             r_fs;
    logic [7:0]       r_red;
    logic [7:0]       r_grn;
    logic [7:0]       r_blu;

    logic             w_adv;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [DIV_W-1:0] w_div_next;
    logic [CB-1:0]    w_h_next;
    logic [CB-1:0]    w_v_next;
    logic [CB:0]      w_h_ext;
    logic [CB:0]      w_v_ext;
    logic             w_hs_next;
    logic             w_vs_next;
    logic             w_bright_next;

    always_comb begin
        w_adv      = enable && (r_div == DIV_LAST);
        w_div_next = w_adv ? '0 : r_div + DIV_W'(1);

        w_h_wrap = (r_h == H_LAST);
        w_v_wrap = (r_v == V_LAST);

        w_h_next = w_h_wrap ? '0 : r_h + CB'(1);

        // Lines only step when the pixel counter rolls over.
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? '0 : r_v + CB'(1);
        end
    end

    // Syncs and bright are decoded from the counts about to be loaded,
    // so the registered outputs line up with the presented counts.
    always_comb begin
        w_h_ext = {1'b0, w_h_next};
        w_v_ext = {1'b0, w_v_next};

        w_hs_next = ~H_ACT;
        if (w_h_ext >= H_SS && w_h_ext < H_SE) begin
            w_hs_next = H_ACT;
        end

        w_vs_next = ~V_ACT;
        if (w_v_ext >= V_SS && w_v_ext < V_SE) begin
            w_vs_next = V_ACT;
        end

        w_bright_next = (w_h_ext < H_VIS) && (w_v_ext < V_VIS);
    end

    always_ff @(posedge clk_50MHz) begin
        if (clear) begin
            r_div    <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_pix_en <= 1'b0;
            r_hs     <= ~H_ACT;
            r_vs     <= ~V_ACT;
            r_bright <= 1'b1;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
            r_red    <= 8'h00;
            r_grn    <= 8'h00;
            r_blu    <= 8'h00;
        end else begin
            r_pix_en <= w_adv;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;

            if (enable) begin
                r_div <= w_div_next;
            end

            if (w_adv) begin
                r_h      <= w_h_next;
                r_v      <= w_v_next;
                r_hs     <= w_hs_next;
                r_vs     <= w_vs_next;
                r_bright <= w_bright_next;
                r_ls     <= w_h_wrap;
                r_fs     <= w_h_wrap && w_v_wrap;
            end

            // Colour tracks the presented bright with one clk of latency,
            // independent of enable.
            r_red <= r_bright ? red_in   : 8'h00;
            r_grn <= r_bright ? green_in : 8'h00;
            r_blu <= r_bright ? blue_in  : 8'h00;
        end
    end

    assign pix_en      = r_pix_en;
    assign h_sync      = r_hs;
    assign v_sync      = r_vs;
    assign bright      = r_bright;
    assign h_count     = r_h;
    assign v_count     = r_v;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
    assign sync_n      = 1'b0;
    assign blank_n     = r_bright;
    assign red_out     = r_red;
    assign green_out   = r_grn;
    assign blue_out    = r_blu;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- H_RES 640: visible pixels per line.
- H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch, in pixels.
- V_RES 480: visible lines.
- V_FP 10, V_SYNC 2, V_BP 33: vertical front porch, sync and back porch, in lines.
- COUNTER_BITS 10: width of h_count and v_count.
- CLK_DIV 2: clk_50MHz cycles per pixel; must be 2 or more.
- H_POL 0, V_POL 0: sync polarity; 0 means active-low, 1 means active-high.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_50MHz, in, 1: the single clock.
- clear, in, 1: reset; synchronous, active-high.
- enable, in, 1: run/hold control for the timing.
- red_in, green_in, blue_in, in, 8 each: pixel colour.
- pix_en, out, 1: pixel-rate tick, one clk wide.
- h_sync, v_sync, out, 1 each: sync outputs.
- bright, out, 1: high in the visible region.
- h_count, v_count, out, COUNTER_BITS each: current position.
- line_start, frame_start, out, 1 each: one-clk pulses.
- sync_n, blank_n, out, 1 each: DAC control.
- red_out, green_out, blue_out, out, 8 each: blank-gated colour.

REQ-003 H_TOTAL SHALL be H_RES+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be V_RES+V_FP+V_SYNC+V_BP.
REQ-004 Elaboration SHALL fail if H_TOTAL-1 or V_TOTAL-1 does not fit in COUNTER_BITS, or if CLK_DIV < 2.

Function
REQ-005 A divider counter div SHALL count 0..CLK_DIV-1 and wrap to 0.
- It advances only while enable=1.
- It holds its value while enable=0.
REQ-006 pix_en SHALL be registered and high for exactly the one clk cycle after each clk edge at which div wrapped from CLK_DIV-1 to 0.
REQ-007 On each clk edge where enable=1 and div=CLK_DIV-1 (an advance edge), h_count SHALL increment, and wrap from H_TOTAL-1 to 0.
REQ-008 v_count SHALL increment only on an advance edge where h_count wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-009 h_sync SHALL be registered and updated on the same edge as the counters, so that it always corresponds to the h_count value currently presented.
- Active (level H_POL) iff H_RES+H_FP <= h_count < H_RES+H_FP+H_SYNC.
- Otherwise at level !H_POL.
REQ-010 v_sync SHALL follow the same rule using v_count, V_RES+V_FP, V_SYNC and V_POL.
REQ-011 bright SHALL be registered and equal 1 iff h_count < H_RES and v_count < V_RES, evaluated on the presented counts.
REQ-012 line_start SHALL be high for the one clk cycle following an advance edge that sets h_count to 0.
REQ-013 frame_start SHALL be high for the one clk cycle following an advance edge that sets both h_count and v_count to 0.
- line_start is also high in that cycle.
REQ-014 Colour outputs SHALL be registered with one clk of latency: on every clk edge, red_out <= bright ? red_in : 0, and likewise for green and blue.
- With CLK_DIV >= 2 this keeps colour inside the same pixel period.
REQ-015 sync_n SHALL be a constant 0, and blank_n SHALL equal bright.
REQ-016 When enable=0, div, the counters, h_sync, v_sync and bright SHALL hold their values, and pix_en, line_start and frame_start SHALL be 0.
- Colour registers keep updating per REQ-014.
REQ-017 clear SHALL take priority over enable at every edge.

Reset
REQ-018 When clear=1 at a clk edge, the block SHALL take these values on the next cycle:
- div=0, h_count=0, v_count=0.
- pix_en=0, line_start=0, frame_start=0.
- h_sync=!H_POL, v_sync=!V_POL.
- bright=1, blank_n=1, sync_n=0.
- red_out, green_out, blue_out = 0.
REQ-019 clear asserted mid-line or mid-frame SHALL abort the frame with no partial sync pulse completing.
- The first advance edge after release SHALL move h_count to 1, and no frame_start is produced for that edge.

Verification
REQ-020 The bench SHALL cover the following directed scenarios (default parameters):
- Free-run timing: clear for 3 clks, enable=1 -> pix_en every 2nd clk; h_count reaches 799 then 0; line period 1600 clks; frame period 840000 clks; frame_start exactly once per frame.
- Horizontal sync and blanking: h_sync=0 exactly for h_count 656..751 (96 pixels); bright=0 from h_count 640 to 799.
- Vertical sync and colour gating: v_sync=0 exactly for v_count 490..491; colour input 0xFF/0x80/0x01 -> red_out/green_out/blue_out = 0xFF/0x80/0x01 in the visible region and 0 at v_count 480..524.
- Hold: enable=0 for 100 clks at h_count=300, v_count=10 -> counts, syncs and bright unchanged, no pix_en pulses; resumes at h_count 301 after enable=1.
- Reset mid-frame: clear at h_count=700, v_count=491 -> next cycle counts 0/0, h_sync=1, v_sync=1, bright=1, all colour outputs 0.
- Parameter variant: H_POL=1, V_POL=1, CLK_DIV=4, H_RES=320, H_FP=8, H_SYNC=48, H_BP=24 -> h_sync=1 only for h_count 328..375; pix_en every 4th clk; H_TOTAL=400.
